// File: rtl/mega99_wb_pkg.sv
// Shared types and constants for the mainboard Wishbone master arbiter.
//   arb_state_t        : arbiter FSM states
//   OWNER_M0/OWNER_M1  : values of the last-grant register
//   WB_DAT_BITS        : Wishbone data width (8-bit mainboard bus)
//   WB_ADR_BITS        : default Wishbone address width
package mega99_wb_pkg;

   localparam int unsigned WB_DAT_BITS = 8;
   localparam int unsigned WB_ADR_BITS = 24;

   localparam logic OWNER_M0 = 1'b0;
   localparam logic OWNER_M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1,
      ABORT
   } arb_state_t;

endpackage

// File: rtl/wb_stall_watchdog.sv
// Stall watchdog for one strobed Wishbone access.
// Counts cycles while en_i is high (strobe pending, no ack); any cycle with en_i low or clr_i
// high restarts the count. terminal_o flags the last allowed cycle of a stalled access.
// Ports:
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset
//   en_i       : access is strobed and unacknowledged this cycle
//   clr_i      : arbiter changes state this cycle
//   terminal_o : count reached TIMEOUT_CYCLES-1 with en_i high
module wb_stall_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_BITS       = 11
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic terminal_o
);

   logic [CNT_BITS-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d      = '0;
      terminal_o = en_i && (cnt_q == CNT_BITS'(TIMEOUT_CYCLES - 1));
      if (en_i && !clr_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin arbiter for the mainboard's single 8-bit Wishbone slave port.
// m0 = overlay/debug CPU, m1 = SD/flash image loader DMA. The grant is held while the owner
// keeps cyc high; on release the bus is handed straight to a waiting master.
// Optional stall watchdog: define MEGA99_WB_ARB_WATCHDOG_EN to abort accesses that wait more
// than TIMEOUT_CYCLES for ack (mN_err_o pulse, then ABORT until the master drops cyc).
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   mN_*  (N=0,1)        : Wishbone master-side ports (adr/dat/we/sel/stb/cyc in, dat/ack/err out)
//   s_*                  : Wishbone port toward the mainboard slave decoder
//   owner                : debug, bit0 = m0 granted, bit1 = m1 granted
module wb_master_arbiter
   import mega99_wb_pkg::*;
#(
   parameter int unsigned ADR_BITS       = WB_ADR_BITS,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned CNT_BITS       = 11
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [0:ADR_BITS-1]    m0_adr_i,
   input  logic [WB_DAT_BITS-1:0] m0_dat_i,
   output logic [WB_DAT_BITS-1:0] m0_dat_o,
   input  logic                   m0_we_i,
   input  logic                   m0_sel_i,
   input  logic                   m0_stb_i,
   input  logic                   m0_cyc_i,
   output logic                   m0_ack_o,
   output logic                   m0_err_o,
   input  logic [0:ADR_BITS-1]    m1_adr_i,
   input  logic [WB_DAT_BITS-1:0] m1_dat_i,
   output logic [WB_DAT_BITS-1:0] m1_dat_o,
   input  logic                   m1_we_i,
   input  logic                   m1_sel_i,
   input  logic                   m1_stb_i,
   input  logic                   m1_cyc_i,
   output logic                   m1_ack_o,
   output logic                   m1_err_o,
   output logic [0:ADR_BITS-1]    s_adr_o,
   output logic [WB_DAT_BITS-1:0] s_dat_o,
   input  logic [WB_DAT_BITS-1:0] s_dat_i,
   output logic                   s_we_o,
   output logic                   s_sel_o,
   output logic                   s_stb_o,
   output logic                   s_cyc_o,
   input  logic                   s_ack_i,
   output logic [1:0]             owner
);

   if (TIMEOUT_CYCLES < 2 || (TIMEOUT_CYCLES >> CNT_BITS) != 0) begin : gen_bad_cfg
      $error("wb_master_arbiter: TIMEOUT_CYCLES must be >= 2 and fit in CNT_BITS");
   end

   arb_state_t state_q, state_d;
   logic       last_grant_q, last_grant_d;
   logic       wd_terminal;  // owner's access timed out this cycle and was not acked

   // Next state and grant bookkeeping
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      unique case (state_q)
         IDLE: begin
            // On a tie the master that was not granted last wins
            if (m0_cyc_i && (!m1_cyc_i || last_grant_q == OWNER_M1)) begin
               state_d      = OWN0;
               last_grant_d = OWNER_M0;
            end else if (m1_cyc_i) begin
               state_d      = OWN1;
               last_grant_d = OWNER_M1;
            end
         end
         OWN0: begin
            if (wd_terminal) begin
               state_d = ABORT;
            end else if (!m0_cyc_i) begin
               if (m1_cyc_i) begin
                  state_d      = OWN1;
                  last_grant_d = OWNER_M1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         OWN1: begin
            if (wd_terminal) begin
               state_d = ABORT;
            end else if (!m1_cyc_i) begin
               if (m0_cyc_i) begin
                  state_d      = OWN0;
                  last_grant_d = OWNER_M0;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         ABORT: begin
            // last_grant still names the aborted master
            if (last_grant_q == OWNER_M0 ? !m0_cyc_i : !m1_cyc_i) begin
               state_d = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= OWNER_M1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Master/slave mux; the non-owner sees an idle bus
   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = '0;
      s_we_o   = 1'b0;
      s_sel_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_cyc_o  = 1'b0;
      m0_dat_o = '0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m1_dat_o = '0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      owner    = {state_q == OWN1, state_q == OWN0};
      unique case (state_q)
         OWN0: begin
            s_adr_o  = m0_adr_i;
            s_dat_o  = m0_dat_i;
            s_we_o   = m0_we_i;
            s_sel_o  = m0_sel_i;
            s_stb_o  = m0_stb_i;
            s_cyc_o  = 1'b1;
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i && m0_stb_i;  // stray acks without a strobe are dropped
            m0_err_o = wd_terminal;
         end
         OWN1: begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_we_o   = m1_we_i;
            s_sel_o  = m1_sel_i;
            s_stb_o  = m1_stb_i;
            s_cyc_o  = 1'b1;
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i && m1_stb_i;
            m1_err_o = wd_terminal;
         end
         IDLE, ABORT: ;
      endcase
   end

`ifdef MEGA99_WB_ARB_WATCHDOG_EN
   logic wd_en;
   logic wd_clr;

   // Terminal is qualified by !s_ack_i, so an ack on the last cycle wins over err
   assign wd_en  = (state_q == OWN0 || state_q == OWN1) && s_stb_o && !s_ack_i;
   assign wd_clr = (state_d != state_q);

   wb_stall_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .CNT_BITS      (CNT_BITS)
   ) u_stall_watchdog (
      .clk_i     (clk),
      .rst_i     (reset),
      .en_i      (wd_en),
      .clr_i     (wd_clr),
      .terminal_o(wd_terminal)
   );
`else
   assign wd_terminal = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
module tb_wb_master_arbiter;

   localparam int unsigned AW = 24;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [0:AW-1] m0_adr, m1_adr, s_adr_o;
   logic [7:0]    m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
   logic          m0_we, m0_sel, m0_stb, m0_cyc, m0_ack_o, m0_err_o;
   logic          m1_we, m1_sel, m1_stb, m1_cyc, m1_ack_o, m1_err_o;
   logic          s_we_o, s_sel_o, s_stb_o, s_cyc_o, s_ack_i;
   logic [1:0]    owner;

   int total = 0;
   int bad   = 0;

   logic [7:0]  exp_q[$];
   logic [31:0] wr_q[$];
   logic [1:0]  grant_q[$];

   always #5 clk = ~clk;

   wb_master_arbiter #(
      .ADR_BITS      (AW),
      .TIMEOUT_CYCLES(8),
      .CNT_BITS      (4)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .m0_adr_i(m0_adr),
      .m0_dat_i(m0_dat),
      .m0_dat_o(m0_dat_o),
      .m0_we_i (m0_we),
      .m0_sel_i(m0_sel),
      .m0_stb_i(m0_stb),
      .m0_cyc_i(m0_cyc),
      .m0_ack_o(m0_ack_o),
      .m0_err_o(m0_err_o),
      .m1_adr_i(m1_adr),
      .m1_dat_i(m1_dat),
      .m1_dat_o(m1_dat_o),
      .m1_we_i (m1_we),
      .m1_sel_i(m1_sel),
      .m1_stb_i(m1_stb),
      .m1_cyc_i(m1_cyc),
      .m1_ack_o(m1_ack_o),
      .m1_err_o(m1_err_o),
      .s_adr_o (s_adr_o),
      .s_dat_o (s_dat_o),
      .s_dat_i (s_dat_i),
      .s_we_o  (s_we_o),
      .s_sel_o (s_sel_o),
      .s_stb_o (s_stb_o),
      .s_cyc_o (s_cyc_o),
      .s_ack_i (s_ack_i),
      .owner   (owner)
   );

   // Slave read data as a function of the full address
   function automatic logic [7:0] rd_data(input logic [0:AW-1] a);
      return a[16:23] ^ a[0:7] ^ 8'h3C;
   endfunction

   task automatic idle_inputs();
      m0_adr = '0; m0_dat = '0; m0_we = 0; m0_sel = 0; m0_stb = 0; m0_cyc = 0;
      m1_adr = '0; m1_dat = '0; m1_we = 0; m1_sel = 0; m1_stb = 0; m1_cyc = 0;
      s_ack_i = 0; s_dat_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      s_ack_i = 1'b1;
      s_dat_i = 8'hFF;
      @(negedge clk);
      total++;
      if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o} !== 8'h00) begin
         bad++;
         $display("FAIL reset_ctl: got %b want 00000000",
                  {s_cyc_o, s_stb_o, s_we_o, s_sel_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o});
      end
      total++;
      if (owner !== 2'b00) begin
         bad++; $display("FAIL reset_owner: got %b want 00", owner);
      end
      total++;
      if (m0_dat_o !== 8'h00 || m1_dat_o !== 8'h00) begin
         bad++; $display("FAIL reset_dat: got %h/%h want 00/00", m0_dat_o, m1_dat_o);
      end
      total++;
      if (s_adr_o !== '0 || s_dat_o !== 8'h00) begin
         bad++; $display("FAIL reset_sbus: adr %h dat %h want 0/00", s_adr_o, s_dat_o);
      end
      s_ack_i = 0;
      s_dat_i = '0;
   endtask

   task automatic test_tie_handover();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_sel = 1; m0_adr = 24'h000010;
      m1_cyc = 1; m1_stb = 1; m1_sel = 1; m1_adr = 24'h000020;
      @(negedge clk);
      total++;
      if (s_cyc_o !== 1'b0) begin
         bad++; $display("FAIL tie_latency: s_cyc_o %b want 0", s_cyc_o);
      end
      @(posedge clk); #1;
      s_ack_i = 1; s_dat_i = 8'h5E;
      @(negedge clk);
      total++;
      if (owner !== 2'b01 || s_adr_o !== 24'h000010) begin
         bad++; $display("FAIL tie_grant: owner %b adr %h want 01/000010", owner, s_adr_o);
      end
      total++;
      if (m0_ack_o !== 1'b1 || m0_dat_o !== 8'h5E) begin
         bad++; $display("FAIL tie_m0_ack: ack %b dat %h want 1/5e", m0_ack_o, m0_dat_o);
      end
      total++;
      if (m1_ack_o !== 1'b0 || m1_dat_o !== 8'h00 || m1_err_o !== 1'b0) begin
         bad++; $display("FAIL tie_m1_blocked: ack %b dat %h err %b want 0/00/0",
                         m1_ack_o, m1_dat_o, m1_err_o);
      end
      @(posedge clk); #1;
      s_ack_i = 0; m0_cyc = 0; m0_stb = 0;
      @(negedge clk);
      total++;
      if (s_cyc_o !== 1'b1 || owner !== 2'b01) begin
         bad++; $display("FAIL handover_release: cyc %b owner %b want 1/01", s_cyc_o, owner);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (s_cyc_o !== 1'b1 || owner !== 2'b10 || s_adr_o !== 24'h000020) begin
         bad++; $display("FAIL handover_m1: cyc %b owner %b adr %h want 1/10/000020",
                         s_cyc_o, owner, s_adr_o);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_burst();
      int         acks = 0;
      int         guard = 0;
      logic       got;
      logic       m0_seen = 0;
      logic [7:0] exp;
      do_reset();
      m1_cyc = 1; m1_stb = 1; m1_sel = 1; m1_adr = 24'h100000;
      exp_q.push_back(rd_data(24'h100000));
      while (acks < 3 && guard < 20) begin
         @(negedge clk);
         if (guard == 2) begin
            m0_cyc = 1; m0_stb = 1; m0_sel = 1; m0_adr = 24'h000555;
         end
         // Zero-wait slave: acks any strobe in the same cycle
         s_ack_i = s_stb_o;
         s_dat_i = rd_data(s_adr_o);
         #1;
         got = m1_ack_o;
         if (owner[0] === 1'b1 || m0_ack_o === 1'b1) m0_seen = 1;
         if (got === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL burst_extra_ack: dat %h with nothing expected", m1_dat_o);
            end else begin
               exp = exp_q.pop_front();
               if (m1_dat_o !== exp) begin
                  bad++; $display("FAIL burst_data: got %h want %h", m1_dat_o, exp);
               end
            end
            acks++;
         end
         @(posedge clk); #1;
         s_ack_i = 0;
         if (got === 1'b1) begin
            if (acks < 3) begin
               m1_adr = AW'(32'h100000 + acks);
               exp_q.push_back(rd_data(m1_adr));
            end else begin
               m1_cyc = 0; m1_stb = 0;
            end
         end
         guard++;
      end
      total++;
      if (acks != 3) begin
         bad++; $display("FAIL burst_ack_count: got %0d want 3", acks);
      end
      total++;
      if (m0_seen !== 1'b0) begin
         bad++; $display("FAIL burst_m0_stall: m0 served mid-burst (1) want 0");
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (owner !== 2'b01 || s_adr_o !== 24'h000555) begin
         bad++; $display("FAIL burst_m0_after: owner %b adr %h want 01/000555", owner, s_adr_o);
      end
      exp_q.delete();
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_round_robin();
      logic       m1_last = 1'b1;  // state right after reset
      logic [1:0] exp_g;
      do_reset();
      for (int r = 0; r < 4; r++) begin
         m0_cyc = 1; m0_stb = 1; m0_sel = 1; m0_adr = AW'(32'h200000 + r);
         m1_cyc = 1; m1_stb = 1; m1_sel = 1; m1_adr = AW'(32'h210000 + r);
         grant_q.push_back(m1_last ? 2'b01 : 2'b10);
         m1_last = ~m1_last;
         @(posedge clk); #1;
         @(negedge clk);
         exp_g = grant_q.pop_front();
         total++;
         if (owner !== exp_g) begin
            bad++; $display("FAIL rr_grant round %0d: got %b want %b", r, owner, exp_g);
         end
         idle_inputs();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_write_wait();
      logic [31:0] wr;
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 1; m0_adr = 24'h000123; m0_dat = 8'hA5;
      wr_q.push_back({24'h000123, 8'hA5});
      @(posedge clk); #1;
      for (int w = 0; w < 5; w++) begin
         @(negedge clk);
         total++;
         if (s_we_o !== 1'b1 || s_dat_o !== 8'hA5 || s_adr_o !== 24'h000123 || s_stb_o !== 1'b1) begin
            bad++; $display("FAIL write_hold wait %0d: we %b dat %h adr %h stb %b want 1/a5/000123/1",
                            w, s_we_o, s_dat_o, s_adr_o, s_stb_o);
         end
         total++;
         if (m0_ack_o !== 1'b0 || m0_err_o !== 1'b0) begin
            bad++; $display("FAIL write_early wait %0d: ack %b err %b want 0/0", w, m0_ack_o, m0_err_o);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      s_ack_i = 1;
      #1;
      total++;
      if (m0_ack_o !== 1'b1 || m0_err_o !== 1'b0) begin
         bad++; $display("FAIL write_ack: ack %b err %b want 1/0", m0_ack_o, m0_err_o);
      end
      wr = wr_q.pop_front();
      total++;
      if ({s_adr_o, s_dat_o} !== wr) begin
         bad++; $display("FAIL write_data: got %h want %h", {s_adr_o, s_dat_o}, wr);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
   endtask

`ifdef MEGA99_WB_ARB_WATCHDOG_EN
   task automatic test_watchdog();
      logic       exp_err;
      logic [1:0] exp_own;
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_sel = 1; m0_adr = 24'h000777;
      for (int c = 0; c <= 14; c++) begin
         if (c == 2) begin
            m1_cyc = 1; m1_stb = 1; m1_sel = 1; m1_adr = 24'h000888;
         end
         if (c == 11) begin
            m0_cyc = 0; m0_stb = 0;
         end
         @(negedge clk);
         exp_err = (c == 8);
         exp_own = (c >= 1 && c <= 8) ? 2'b01 : (c >= 13) ? 2'b10 : 2'b00;
         total++;
         if (m0_err_o !== exp_err || m1_err_o !== 1'b0) begin
            bad++; $display("FAIL wdog_err cycle %0d: m0 %b m1 %b want %b/0", c, m0_err_o, m1_err_o, exp_err);
         end
         total++;
         if (owner !== exp_own || s_stb_o !== (exp_own != 2'b00) || s_cyc_o !== (exp_own != 2'b00)) begin
            bad++; $display("FAIL wdog_bus cycle %0d: owner %b stb %b cyc %b want owner %b",
                            c, owner, s_stb_o, s_cyc_o, exp_own);
         end
         @(posedge clk); #1;
      end
      idle_inputs();
      @(posedge clk); #1;
   endtask
`else
   task automatic test_watchdog();
      do_reset();
      m0_cyc = 1; m0_stb = 1; m0_sel = 1; m0_adr = 24'h000777;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         total++;
         if (m0_err_o !== 1'b0 || m1_err_o !== 1'b0) begin
            bad++; $display("FAIL nowdog_err cycle %0d: m0 %b m1 %b want 0/0", c, m0_err_o, m1_err_o);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      s_ack_i = 1;
      #1;
      total++;
      if (owner !== 2'b01 || m0_ack_o !== 1'b1) begin
         bad++; $display("FAIL nowdog_late_ack: owner %b ack %b want 01/1", owner, m0_ack_o);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(posedge clk); #1;
   endtask
`endif

   task automatic test_reset_mid();
      do_reset();
      m1_cyc = 1; m1_stb = 1; m1_sel = 1; m1_we = 1; m1_dat = 8'h99; m1_adr = 24'h300000;
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (owner !== 2'b10 || s_stb_o !== 1'b1) begin
         bad++; $display("FAIL rstmid_pre: owner %b stb %b want 10/1", owner, s_stb_o);
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      s_ack_i = 1; s_dat_i = 8'h77;
      #1;
      total++;
      if ({s_cyc_o, s_stb_o, s_we_o, s_sel_o, owner} !== 6'b000000 || s_adr_o !== '0 || s_dat_o !== 8'h00) begin
         bad++; $display("FAIL rstmid_bus: cyc %b stb %b we %b sel %b owner %b adr %h dat %h want all 0",
                         s_cyc_o, s_stb_o, s_we_o, s_sel_o, owner, s_adr_o, s_dat_o);
      end
      total++;
      if (m1_ack_o !== 1'b0 || m1_dat_o !== 8'h00 || m1_err_o !== 1'b0) begin
         bad++; $display("FAIL rstmid_late_ack: ack %b dat %h err %b want 0/00/0",
                         m1_ack_o, m1_dat_o, m1_err_o);
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_tie_handover();
      test_burst();
      test_round_robin();
      test_write_wait();
      test_watchdog();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench still running at %0t, want finished", $time);
      $fatal(1, "bench timed out");
   end

endmodule

// File: doc/wb_master_arbiter.md
Name: wb_master_arbiter

Overview:
- Shares the mainboard's single 8-bit Wishbone slave port between two masters:
  - m0 is the overlay/debug CPU.
  - m1 is the SD/flash image loader DMA.
- Sits between those masters and the mainboard's wb_* port, which decodes onward to VDP, console ROM, GROM, cartridge ROM, speech ROM and PEB.
- Arbitration is round-robin with cycle locking (grant held while the owner keeps cyc high).
- An optional stall watchdog keeps one hung slave from freezing both masters.

Parameters:
- ADR_BITS, 24: Wishbone address width, MSB-first [0:ADR_BITS-1].
- TIMEOUT_CYCLES, 1024: clk cycles an strobed access may wait for ack before abort (watchdog only); minimum 2.
- CNT_BITS, 11: watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- mN_adr_i (N=0,1)  input  ADR_BITS  master N address.
- mN_dat_i  input  8  master N write data.
- mN_dat_o  output  8  read data to master N.
- mN_we_i  input  1  master N write enable.
- mN_sel_i  input  1  master N byte select.
- mN_stb_i  input  1  master N strobe.
- mN_cyc_i  input  1  master N cycle / bus-lock request.
- mN_ack_o  output  1  ack to master N.
- mN_err_o  output  1  watchdog abort to master N (always 0 without the optional feature).
- s_adr_o  output  ADR_BITS  to mainboard wb_adr_i.
- s_dat_o  output  8  to wb_dat_i.
- s_dat_i  input  8  from wb_dat_o.
- s_we_o, s_sel_o, s_stb_o, s_cyc_o  output  1 each  to the matching mainboard inputs.
- s_ack_i  input  1  from wb_ack_o.
- owner  output  2  debug: bit0 = m0 granted, bit1 = m1 granted.

Behaviour:
- States: IDLE, OWN0, OWN1, ABORT. Register last_grant: 0 means m0 was granted last.
- Reset:
  - state=IDLE, last_grant=1 (so m0 wins the first tie), watchdog count=0.
  - All s_* outputs, mN_ack_o, mN_err_o and owner are 0; mN_dat_o = 8'h00.
- IDLE:
  - Only m0_cyc_i high -> OWN0 next cycle.
  - Only m1_cyc_i high -> OWN1 next cycle.
  - Both high -> grant the master that is not last_grant.
  - Grant latency: s_cyc_o rises exactly 1 cycle after mN_cyc_i is first seen.
- OWNn:
  - s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o are combinational copies of master n's signals; s_cyc_o=1.
  - mn_ack_o = s_ack_i and mn_dat_o = s_dat_i, combinational, so there is no added ack latency.
  - The non-owner sees ack=0, err=0, dat=8'h00. Its stb is ignored and it waits.
  - When mn_cyc_i falls:
    - If the other master's cyc is high -> direct handover to OWN(other) next cycle; s_cyc_o stays high but the master fields change.
    - Otherwise -> IDLE.
  - last_grant updates on every grant.
  - s_ack_i arriving while s_stb_o=0 is dropped and not forwarded.
- Watchdog (feature on):
  - Counts while in OWNn with s_stb_o=1 and s_ack_i=0; clears on ack, on stb low, and on any state change.
  - When count reaches TIMEOUT_CYCLES-1 with no ack that cycle: mn_err_o=1 for exactly 1 cycle, s_stb_o and s_cyc_o forced 0 from the next cycle, then enter ABORT.
  - ack and err are never asserted in the same cycle; ack wins if s_ack_i arrives on the terminal cycle.
- ABORT:
  - s_* outputs idle (0).
  - Stays until the aborted master drops cyc, then IDLE.
  - The other master cannot be granted while in ABORT.
- Reset mid-cycle: the access is dropped immediately next clk and outputs return to reset values. A slave ack arriving afterwards is ignored because stb=0.

Optional Feature:
- Macro: MEGA99_WB_ARB_WATCHDOG_EN.
- Defined: counter, ABORT state and mN_err_o behave as above.
- Undefined:
  - No counter, no ABORT state.
  - mN_err_o tied to 0.
  - An owner waits for ack indefinitely.

Decomposition:
- Package mega99_wb_pkg holds:
  - the arb_state_t enum (IDLE/OWN0/OWN1/ABORT);
  - owner index constants OWNER_M0=0, OWNER_M1=1;
  - WB_DAT_BITS=8 and the default WB_ADR_BITS=24.
- Sub-module wb_stall_watchdog: counter plus terminal flag, parameterised by TIMEOUT_CYCLES/CNT_BITS, instantiated only under the macro.
- The master/slave mux stays inline.

Test Plan:
- After reset, m0 and m1 raise cyc+stb in the same cycle -> OWN0 one cycle later, s_adr_o = m0_adr_i. After m0 drops cyc, OWN1 on the next cycle with no IDLE gap.
- m1 alone holds cyc across 3 back-to-back reads (addr 0x100000..0x100002), slave acks each in 1 cycle; m0 requests mid-burst -> m0 stalled until m1 drops cyc, and m1 gets 3 acks with the correct data.
- Alternating contention over 4 cycles of requests -> grants alternate m0,m1,m0,m1 (round-robin).
- m0 writes 0xA5 to 0x000123, slave ack delayed 5 cycles -> s_we_o=1 and s_dat_o=0xA5 held stable until ack; m0_ack_o rises in the same cycle as s_ack_i.
- Watchdog on, TIMEOUT_CYCLES=8, slave never acks -> m0_err_o pulses for 1 cycle, 8 cycles after stb; s_stb_o=0 next cycle; m1 is granted only after m0 drops cyc.
- reset asserted during OWN1 with stb high -> next cycle all outputs 0, state IDLE; a late s_ack_i is not forwarded to m1.
